// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch stage. Four byte reads per instruction,
// assembled little-endian and handed to ID over valid/ready.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        if_request_o,
  output logic [31:0] if_addr_o,
  input  logic        if_grant_i,
  input  logic [7:0]  mem_data_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  input  logic        id_ready_i
);

  localparam logic [0:0] FETCH = 1'b0;
  localparam logic [0:0] HOLD  = 1'b1;

  logic [0:0]  state;
  logic [31:0] pc;
  logic [2:0]  issue_cnt;
  logic        pend;
  logic [1:0]  pend_idx;
  logic [31:0] asm_buf;

  logic accept;
  logic capture;
  logic last_byte;
  logic handshake;

  assign if_request_o = !rst
                     && !branch_flag_i
                     && (state == FETCH)
                     && (issue_cnt < 3'd4);

  assign if_addr_o = pc + {29'd0, issue_cnt};

  assign accept    = if_request_o && if_grant_i;
  // a byte landing in a branch cycle belongs to the old stream
  assign capture   = pend && !branch_flag_i;
  assign last_byte = capture && (pend_idx == 2'd3);
  assign handshake = inst_valid_o && id_ready_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= FETCH;
      pc           <= RESET_PC;
      issue_cnt    <= 3'd0;
      pend         <= 1'b0;
      pend_idx     <= 2'd0;
      asm_buf      <= 32'd0;
      inst_valid_o <= 1'b0;
      inst_o       <= 32'd0;
      inst_pc_o    <= 32'd0;
    end else if (branch_flag_i) begin
      state        <= FETCH;
      pc           <= branch_target_i;
      issue_cnt    <= 3'd0;
      pend         <= 1'b0;
      inst_valid_o <= 1'b0;
    end else begin
      pend <= accept;
      if (accept) begin
        issue_cnt <= issue_cnt + 3'd1;
        pend_idx  <= issue_cnt[1:0];
      end
      if (capture) begin
        asm_buf[{pend_idx, 3'b000} +: 8] <= mem_data_i;
      end
      unique case (state)
        FETCH: begin
          if (last_byte) begin
            state        <= HOLD;
            inst_o       <= {mem_data_i, asm_buf[23:0]};
            inst_pc_o    <= pc;
            inst_valid_o <= 1'b1;
          end
        end
        HOLD: begin
          if (handshake) begin
            state        <= FETCH;
            pc           <= pc + 32'd4;
            issue_cnt    <= 3'd0;
            inst_valid_o <= 1'b0;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed plus random stimulus for if_fetch, checked
// against a byte-count / RAM-level model of the fetch stage.
module tb_if_fetch;

  logic        clk;
  logic        rst;
  logic        if_request_o;
  logic [31:0] if_addr_o;
  logic        if_grant_i;
  logic [7:0]  mem_data_i;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        id_ready_i;

  if_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk             (clk),
    .rst             (rst),
    .if_request_o    (if_request_o),
    .if_addr_o       (if_addr_o),
    .if_grant_i      (if_grant_i),
    .mem_data_i      (mem_data_i),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
    .inst_valid_o    (inst_valid_o),
    .inst_o          (inst_o),
    .inst_pc_o       (inst_pc_o),
    .id_ready_i      (id_ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] ram [0:1023];
  int n_chk = 0;
  int n_err = 0;

  logic        acc_v = 1'b0;
  logic [31:0] acc_a = 32'd0;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  // One cycle: drive inputs after the edge, memory returns the byte
  // accepted last cycle, then record this cycle's acceptance mid-cycle.
  task automatic step(input logic g, input logic r, input logic b,
                      input logic [31:0] t, input logic rs);
    @(posedge clk);
    #1;
    mem_data_i      = acc_v ? ram[acc_a[9:0]] : 8'($urandom);
    if_grant_i      = g;
    id_ready_i      = r;
    branch_flag_i   = b;
    branch_target_i = t;
    rst             = rs;
    @(negedge clk);
    acc_v = if_request_o && if_grant_i;
    acc_a = if_addr_o;
  endtask

  // Reference model: PC, bytes requested, bytes received, held result.
  logic        m_known = 1'b0;
  logic [31:0] m_pc;
  int          m_nacc;
  int          m_ncap;
  logic        m_due;
  logic        m_valid;
  logic [31:0] m_inst;
  logic [31:0] m_ipc;

  always @(negedge clk) begin
    logic        e_req;
    logic [31:0] a;
    e_req = !rst && !branch_flag_i && !m_valid && (m_nacc < 4);
    if (m_known) begin
      chk("req", {31'd0, if_request_o}, {31'd0, e_req});
      chk("addr", if_addr_o, m_pc + 32'(m_nacc));
      chk("valid", {31'd0, inst_valid_o}, {31'd0, m_valid});
      chk("inst", inst_o, m_inst);
      chk("inst_pc", inst_pc_o, m_ipc);
    end
    if (rst) begin
      m_known = 1'b1;
      m_pc    = 32'd0;
      m_nacc  = 0;
      m_ncap  = 0;
      m_due   = 1'b0;
      m_valid = 1'b0;
      m_inst  = 32'd0;
      m_ipc   = 32'd0;
    end else if (m_known) begin
      if (branch_flag_i) begin
        m_pc    = branch_target_i;
        m_nacc  = 0;
        m_ncap  = 0;
        m_due   = 1'b0;
        m_valid = 1'b0;
      end else if (m_valid) begin
        if (id_ready_i) begin
          m_valid = 1'b0;
          m_pc    = m_pc + 32'd4;
          m_nacc  = 0;
          m_ncap  = 0;
        end
      end else begin
        if (m_due) begin
          m_ncap++;
          if (m_ncap == 4) begin
            m_valid = 1'b1;
            m_ipc   = m_pc;
            for (int i = 0; i < 4; i++) begin
              a = m_pc + 32'(i);
              m_inst[8*i +: 8] = ram[a[9:0]];
            end
          end
        end
        m_due = e_req && if_grant_i;
        if (m_due) m_nacc++;
      end
    end
  end

  initial begin
    logic [31:0] t;
    rst = 1'b1;
    if_grant_i = 1'b0;
    id_ready_i = 1'b0;
    branch_flag_i = 1'b0;
    branch_target_i = 32'd0;
    mem_data_i = 8'd0;
    for (int i = 0; i < 1024; i++) ram[i] = 8'($urandom);
    ram[0] = 8'h13; ram[1] = 8'h05; ram[2] = 8'h10; ram[3] = 8'h00;
    ram[4] = 8'h93; ram[5] = 8'h02; ram[6] = 8'h30; ram[7] = 8'h00;
    ram[12'h100] = 8'hB7; ram[12'h101] = 8'h12;
    ram[12'h102] = 8'h34; ram[12'h103] = 8'h56;
    ram[12'h040] = 8'h13; ram[12'h041] = 8'h01;
    ram[12'h042] = 8'h01; ram[12'h043] = 8'hFF;

    // reset
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    chk("rst_req", {31'd0, if_request_o}, 32'd0);
    chk("rst_valid", {31'd0, inst_valid_o}, 32'd0);

    // continuous grant from RESET_PC
    for (int c = 0; c < 4; c++) begin
      step(1, 0, 0, 0, 0);
      chk("c_req", {31'd0, if_request_o}, 32'd1);
      chk("c_addr", if_addr_o, 32'(c));
    end
    step(1, 0, 0, 0, 0);
    chk("c4_valid", {31'd0, inst_valid_o}, 32'd0);
    step(1, 1, 0, 0, 0);
    chk("c5_valid", {31'd0, inst_valid_o}, 32'd1);
    chk("c5_inst", inst_o, 32'h0010_0513);
    chk("c5_pc", inst_pc_o, 32'd0);

    // grant withheld on addr 6
    step(1, 0, 0, 0, 0);
    chk("g_addr4", if_addr_o, 32'd4);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("g_addr6a", if_addr_o, 32'd6);
    step(1, 0, 0, 0, 0);
    chk("g_addr6b", if_addr_o, 32'd6);
    step(1, 0, 0, 0, 0);
    chk("g_addr7", if_addr_o, 32'd7);
    step(1, 0, 0, 0, 0);
    chk("g_late", {31'd0, inst_valid_o}, 32'd0);

    // back-pressure for 10 cycles
    for (int c = 0; c < 10; c++) begin
      step(1, 0, 0, 0, 0);
      chk("bp_valid", {31'd0, inst_valid_o}, 32'd1);
      chk("bp_req", {31'd0, if_request_o}, 32'd0);
      chk("bp_inst", inst_o, 32'h0030_0293);
      chk("bp_pc", inst_pc_o, 32'd4);
    end
    step(1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("bp_next", if_addr_o, 32'd8);

    // branch after two accepted bytes
    step(1, 0, 0, 0, 0);
    step(1, 0, 1, 32'h100, 0);
    chk("br_req", {31'd0, if_request_o}, 32'd0);
    for (int c = 0; c < 4; c++) begin
      step(1, 0, 0, 0, 0);
      chk("br_addr", if_addr_o, 32'h100 + 32'(c));
    end
    step(1, 0, 0, 0, 0);
    step(1, 1, 1, 32'h40, 0);
    chk("br_inst", inst_o, 32'h5634_12B7);
    chk("br_pc", inst_pc_o, 32'h100);

    // branch together with handshake
    step(1, 0, 0, 0, 0);
    chk("bh_addr", if_addr_o, 32'h40);
    chk("bh_valid", {31'd0, inst_valid_o}, 32'd0);
    for (int c = 0; c < 4; c++) step(1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    chk("bh_inst", inst_o, 32'hFF01_0113);
    chk("bh_pc", inst_pc_o, 32'h40);

    // reset after two accepted bytes
    step(1, 0, 0, 0, 0);
    chk("rm_addr", if_addr_o, 32'h44);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1);
    chk("rm_req", {31'd0, if_request_o}, 32'd0);
    step(1, 0, 0, 0, 0);
    chk("rm_addr0", if_addr_o, 32'd0);
    chk("rm_valid", {31'd0, inst_valid_o}, 32'd0);
    for (int c = 0; c < 4; c++) step(1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    chk("rm_inst", inst_o, 32'h0010_0513);
    chk("rm_pc", inst_pc_o, 32'd0);

    // random traffic, including wrap-around branch targets
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 3) == 0)
        t = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      else
        t = 32'($urandom_range(0, 1023));
      step(($urandom_range(0, 3) != 0),
           ($urandom_range(0, 1) != 0),
           ($urandom_range(0, 29) == 0),
           t,
           ($urandom_range(0, 199) == 0));
    end
    step(1, 1, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage. Sits directly upstream of the byte-wide memory controller.
- Issues four sequential byte-read requests per instruction and captures the returned RAM bytes. Assembles a little-endian 32-bit instruction.
- Presents the instruction and its PC to ID through a valid/ready handshake.
- Handles arbitration loss (grant withheld while MEM owns RAM) and branch redirects mid-fetch.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset. Synchronous, active-high.
- if_request_o  out  1  byte-read request to the memory controller.
- if_addr_o  out  32  byte address of the current request.
- if_grant_i  in  1  controller is serving IF this cycle; the request is accepted only when if_request_o and if_grant_i are both high.
- mem_data_i  in  8  RAM read byte; valid the cycle after an accepted request.
- branch_flag_i  in  1  redirect fetch.
- branch_target_i  in  32  redirect PC.
- inst_valid_o  out  1  inst_o/inst_pc_o hold a complete instruction.
- inst_o  out  32  assembled instruction.
- inst_pc_o  out  32  PC of inst_o.
- id_ready_i  in  1  ID accepts an instruction when inst_valid_o and id_ready_i are both high.

Behaviour:

State:
- pc[31:0]: current fetch address.
- issue_cnt[2:0]: bytes requested, 0..4.
- pend: byte in flight.
- pend_idx[1:0]: index of the in-flight byte.
- buf[31:0]: assembly buffer.
- FSM with states FETCH and HOLD.

Reset (rst high at a rising edge):
- pc = RESET_PC, issue_cnt = 0, pend = 0, buf = 0, state = FETCH.
- inst_valid_o = 0, inst_o = 0, inst_pc_o = 0.
- if_request_o is 0 while rst is high.
- if_addr_o = RESET_PC after reset.
- Reset mid-fetch abandons all in-flight bytes. A byte returned after reset is ignored.

FETCH:
- if_request_o = (issue_cnt < 4). Driven combinationally.
- if_addr_o = pc + issue_cnt, 32-bit wrap-around allowed.
- Accepted request: issue_cnt += 1, pend = 1, pend_idx = issue_cnt. Otherwise pend = 0.
- When pend is 1, mem_data_i is written to buf[8*pend_idx+7 : 8*pend_idx].
- If the byte written is index 3:
  - next state is HOLD;
  - inst_o = {byte3, buf[23:0]};
  - inst_pc_o = pc;
  - inst_valid_o = 1.
- A cycle with grant withheld issues nothing. The address stays the same and is retried in the next cycle.
- Minimum latency with continuous grant: requests in cycles 0..3, captures in cycles 1..4, inst_valid_o high from cycle 5.

HOLD:
- if_request_o = 0.
- Outputs stay stable until the handshake completes.
- On handshake: inst_valid_o = 0, pc += 4, issue_cnt = 0, state = FETCH. The next request goes out in the following cycle.
- id_ready_i may stay low indefinitely. In that case no outputs change.

Branch redirect (branch_flag_i high), highest priority, checked in any state:
- Next cycle: pc = branch_target_i, issue_cnt = 0, pend = 0, inst_valid_o = 0, state = FETCH.
- A byte returning in the same cycle as the branch, or in the cycle after it, from a pre-branch request is discarded.
- if_request_o is forced to 0 in the branch cycle, so no request is accepted there.
- Branch together with a valid+ready handshake: the handshake counts as a transfer, and pc takes branch_target_i, not pc+4.
- rst has priority over the branch.

Arithmetic and width:
- Byte assembly is little-endian: inst_o[7:0] is the byte at inst_pc_o.
- Instructions at a misaligned PC are fetched without trapping.

Test Plan:
- Reset + continuous grant: RAM[0..3] = 13,05,10,00 -> requests at addr 0,1,2,3 in cycles 0..3; inst_valid_o in cycle 5 with inst_o = 0x00100513, inst_pc_o = 0; id_ready_i = 1 -> next request addr 4.
- Grant withheld: if_grant_i low in the cycle that requests addr 2 -> addr 2 is re-presented, 4 distinct accepted requests, inst_valid_o delayed exactly 1 cycle, inst_o still correct.
- Back-pressure: id_ready_i low for 10 cycles after valid -> inst_o/inst_pc_o stable, if_request_o = 0; ready high -> pc advances by 4.
- Branch mid-fetch: branch_flag_i = 1 with target 0x100 after bytes 0,1 were accepted -> in-flight byte discarded, next requests 0x100..0x103, inst_pc_o = 0x100, inst_o = RAM[0x103:0x100].
- Branch during handshake: valid+ready and branch_flag_i with target 0x40 in the same cycle -> one transfer counted, next fetch at 0x40.
- Reset mid-fetch: rst asserted after 2 accepted bytes -> inst_valid_o = 0; the fetch restarts at RESET_PC and the stale byte is not written into inst_o.
